time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
//   Consumes the divided clock from the clock divider stage and keeps 24-hour
//   time (HH:MM:SS, BCD) for the digital clock display path. clk_div_in is
//   sampled as data in the sys_clk domain; it is never used as a clock.
//   Each rising edge of clk_div_in is one tick; TICK_DIV ticks advance time
//   by one second. mode_key and inc_key from the key debouncer let the user
//   set the hour and minute.
// PARAMETERS
//   TICK_DIV  1   clk_div_in rising edges per one-second advance (>=1)
//   TICK_W    16  prescaler width; TICK_DIV <= 2**TICK_W
// PORTS
//   sys_clk     in   1  system clock; every flop runs on its rising edge
//   sys_rst_n   in   1  asynchronous active-low reset
//   clk_div_in  in   1  divided clock level, treated as data
//   mode_key    in   1  1-cycle pulse: step to the next mode
//   inc_key     in   1  1-cycle pulse: increment the selected field
//   hour_bcd    out  8  [7:4] tens 0-2, [3:0] ones 0-9
//   min_bcd     out  8  [7:4] tens 0-5, [3:0] ones 0-9
//   sec_bcd     out  8  [7:4] tens 0-5, [3:0] ones 0-9
//   mode        out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven)
//   sec_tick    out  1  1-cycle pulse in the cycle the seconds field changes
//   day_wrap    out  1  1-cycle pulse in the cycle 23:59:59 becomes 00:00:00
// BEHAVIOUR
//   Reset: all outputs 0; mode=RUN; prescaler 0; sync/edge flops 0.
//   Edge detect: 2-flop synchroniser s0->s1, then prev<=s1; rise=s1&~prev.
//     - A rising edge on clk_div_in is acted on at the 3rd sys_clk edge.
//     - A high clk_div_in at reset release counts as one rise.
//   Prescaler (RUN only): on rise, cnt==TICK_DIV-1 -> cnt<=0 and sec_pulse;
//     otherwise cnt<=cnt+1. In SET modes cnt is held at 0 and rises ignored.
//   Time update, RUN, on sec_pulse (same edge):
//     - sec+1; 59 -> 00 with carry to min.
//     - min 59 + carry -> 00 with carry to hour.
//     - hour: ones 9 -> 0 with tens+1; 23 + carry -> 00, day_wrap=1.
//     - sec_tick=1 on the same edge as the field update.
//   Mode FSM, on mode_key:
//     - RUN -> SET_HOUR -> SET_MIN -> RUN.
//     - Leaving SET_MIN: sec<=00 and prescaler<=0 on that edge.
//   inc_key:
//     - SET_HOUR: hour+1, 23 -> 00. SET_MIN: min+1, 59 -> 00.
//     - No carry into other fields; day_wrap never fires from inc_key.
//     - Ignored in RUN.
//   Simultaneous events:
//     - mode_key and inc_key in the same cycle: mode_key acts, inc_key dropped.
//     - RUN with sec_pulse and mode_key in the same cycle: the time advance
//       is applied and mode goes to SET_HOUR on the same edge.
//     - In SET modes sec_pulse never occurs (prescaler held).
//   Arithmetic: per-digit BCD; no digit ever holds an out-of-range value.
//     hour tens==2 caps ones at 3.
//   Reset mid-operation: asynchronous clear to reset values on any cycle;
//     any partial prescaler count is discarded.
//   mode==11: unreachable; if entered, next edge forces RUN.
// TESTING
//   1 TICK_DIV=1, reset, 5 clk_div_in edges -> sec_bcd=0x05, sec_tick=5 pulses,
//     first pulse exactly 3 sys_clk after the first rise.
//   2 TICK_DIV=4, 8 rises -> sec_bcd=0x02; a sec_tick on every 4th rise only.
//   3 Set 23:59 via keys, exit to RUN, 60 seconds -> 00:00:00, day_wrap one
//     pulse in the same cycle as the sec_tick that takes sec 59 -> 00.
//   4 mode_key x1, inc_key x25 -> hour_bcd 0x01, min/sec unchanged;
//     mode_key x1, inc_key x61 -> min_bcd 0x01, hour_bcd unchanged.
//   5 mode_key+inc_key same cycle in SET_HOUR -> mode=SET_MIN, hour unchanged;
//     RUN with sec_pulse+mode_key same cycle -> sec+1 and mode=SET_HOUR.
//   6 Assert sys_rst_n low mid-count at 12:34:56 -> all outputs 0 immediately
//     (asynchronous), mode=RUN; counting resumes from 00:00:00 after release.

Source files
------------

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day keeper. The divided clock is sampled as data in the sys_clk domain,
// and the hour and minute fields are set from the debounced mode and inc keys.
module time_of_day_counter #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned TICK_W   = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clk_div_in,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       day_wrap
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    BAD      = 2'b11
  } mode_e;

  localparam logic [TICK_W-1:0] CNT_MAX = TICK_W'(TICK_DIV - 1);

  mode_e             mode_q;
  logic [TICK_W-1:0] cnt_q;
  logic [7:0]        hour_q, min_q, sec_q;
  logic              s0_q, s1_q, prev_q;
  logic              sec_tick_q, day_wrap_q;

  logic              rise, sec_pulse;
  logic              sec_c, min_c, hour_c;
  logic [7:0]        sec_inc, min_inc, hour_inc;

  // Returns {carry, next}; a ones digit of 9 or above always rolls over.
  function automatic logic [8:0] inc_mod60(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones < 4'd9)      return {1'b0, tens, ones + 4'd1};
    else if (tens < 4'd5) return {1'b0, tens + 4'd1, 4'd0};
    else                  return {1'b1, 8'h00};
  endfunction

  function automatic logic [8:0] inc_mod24(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (tens >= 4'd2 && ones >= 4'd3) return {1'b1, 8'h00};
    else if (ones < 4'd9)             return {1'b0, tens, ones + 4'd1};
    else                              return {1'b0, tens + 4'd1, 4'd0};
  endfunction

  always_comb begin
    {sec_c, sec_inc}   = inc_mod60(sec_q);
    {min_c, min_inc}   = inc_mod60(min_q);
    {hour_c, hour_inc} = inc_mod24(hour_q);
    rise               = s1_q & ~prev_q;
    sec_pulse          = rise && (mode_q == RUN) && (cnt_q == CNT_MAX);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q     <= RUN;
      cnt_q      <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      prev_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      s0_q       <= clk_div_in;
      s1_q       <= s0_q;
      prev_q     <= s1_q;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      case (mode_q)
        RUN: begin
          if (rise) cnt_q <= sec_pulse ? '0 : cnt_q + TICK_W'(1);
          // Time advance and a mode_key exit may land on the same edge.
          if (sec_pulse) begin
            sec_q      <= sec_inc;
            sec_tick_q <= 1'b1;
            if (sec_c) begin
              min_q <= min_inc;
              if (min_c) begin
                hour_q     <= hour_inc;
                day_wrap_q <= hour_c;
              end
            end
          end
          if (mode_key) mode_q <= SET_HOUR;
        end
        SET_HOUR: begin
          cnt_q <= '0;
          if (mode_key)     mode_q <= SET_MIN;
          else if (inc_key) hour_q <= hour_inc;
        end
        SET_MIN: begin
          cnt_q <= '0;
          if (mode_key) begin
            mode_q <= RUN;
            sec_q  <= '0;
          end else if (inc_key) begin
            min_q <= min_inc;
          end
        end
        default: begin
          mode_q <= RUN;
          cnt_q  <= '0;
        end
      endcase
    end
  end

  assign hour_bcd = hour_q;
  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign mode     = mode_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: two instances (TICK_DIV 1 and 4) share stimulus and are
// compared each cycle against a seconds-of-day reference model, plus directed vectors.
module tb_time_of_day_counter;

  logic sys_clk = 1'b0;
  logic sys_rst_n, clk_div_in, mode_key, inc_key;

  logic [7:0] hr1, mn1, sc1, hr4, mn4, sc4;
  logic [1:0] md1, md4;
  logic       tk1, wr1, tk4, wr4;

  always #5 sys_clk = ~sys_clk;

  time_of_day_counter #(.TICK_DIV(1), .TICK_W(16)) u_div1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div_in(clk_div_in),
    .mode_key(mode_key), .inc_key(inc_key),
    .hour_bcd(hr1), .min_bcd(mn1), .sec_bcd(sc1), .mode(md1),
    .sec_tick(tk1), .day_wrap(wr1)
  );

  time_of_day_counter #(.TICK_DIV(4), .TICK_W(16)) u_div4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div_in(clk_div_in),
    .mode_key(mode_key), .inc_key(inc_key),
    .hour_bcd(hr4), .min_bcd(mn4), .sec_bcd(sc4), .mode(md4),
    .sec_tick(tk4), .day_wrap(wr4)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: time held as seconds since midnight, per instance.
  int       divs[2] = '{1, 4};
  int       mt[2];
  int       mm[2];
  int       mp[2];
  logic     mtick[2];
  logic     mwrap[2];
  logic [2:0] hist;

  int n1, n4, nw1, nwt1;

  typedef struct {
    logic       lvl;
    logic       mk;
    logic       ik;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [1:0] mode;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] expv(input int i);
    return {bcd8(mt[i] / 3600), bcd8((mt[i] / 60) % 60), bcd8(mt[i] % 60),
            2'(mm[i]), mtick[i], mwrap[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mt[i] = 0; mm[i] = 0; mp[i] = 0; mtick[i] = 1'b0; mwrap[i] = 1'b0;
    end
    hist = 3'b000;
  endtask

  task automatic model_edge(input logic lvl, input logic mk, input logic ik);
    logic rise;
    int   hh, mi;
    // A level sampled at edge k is acted on at edge k+2 if it was low at edge k-1.
    rise = hist[1] & ~hist[2];
    for (int i = 0; i < 2; i++) begin
      mtick[i] = 1'b0;
      mwrap[i] = 1'b0;
      case (mm[i])
        0: begin
          if (rise) begin
            if (mp[i] == divs[i] - 1) begin
              mp[i] = 0;
              mt[i]++;
              mtick[i] = 1'b1;
              if (mt[i] == 86400) begin
                mt[i] = 0;
                mwrap[i] = 1'b1;
              end
            end else mp[i]++;
          end
          if (mk) mm[i] = 1;
        end
        1: begin
          mp[i] = 0;
          if (mk) mm[i] = 2;
          else if (ik) begin
            hh = (mt[i] / 3600 + 1) % 24;
            mt[i] = hh * 3600 + mt[i] % 3600;
          end
        end
        default: begin
          mp[i] = 0;
          if (mk) begin
            mm[i] = 0;
            mt[i] = mt[i] - mt[i] % 60;
          end else if (ik) begin
            mi = (mt[i] / 60) % 60;
            mt[i] = mt[i] - mi * 60 + ((mi + 1) % 60) * 60;
          end
        end
      endcase
    end
    hist = {hist[1], hist[0], lvl};
  endtask

  task automatic step(input logic lvl, input logic mk, input logic ik);
    @(negedge sys_clk);
    clk_div_in = lvl;
    mode_key   = mk;
    inc_key    = ik;
    @(posedge sys_clk);
    model_edge(lvl, mk, ik);
    #1;
    check("model_div1", {4'h0, hr1, mn1, sc1, md1, tk1, wr1}, {4'h0, expv(0)});
    check("model_div4", {4'h0, hr4, mn4, sc4, md4, tk4, wr4}, {4'h0, expv(1)});
    n1  += int'(tk1);
    n4  += int'(tk4);
    nw1 += int'(wr1);
    if (wr1 && tk1) nwt1++;
  endtask

  task automatic do_reset();
    clk_div_in = 1'b0;
    mode_key   = 1'b0;
    inc_key    = 1'b0;
    sys_rst_n  = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic rises(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int first;
    logic lvl;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 2'd1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 2'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 2'd2};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 2'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 2'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 2'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 2'd2};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 2'd0};

    // Reset state
    sys_rst_n = 1'b0;
    do_reset();
    check("reset_div1", {4'h0, hr1, mn1, sc1, md1, tk1, wr1}, 32'h0);
    check("reset_div4", {4'h0, hr4, mn4, sc4, md4, tk4, wr4}, 32'h0);

    // Latency and TICK_DIV=1 / TICK_DIV=4 counting
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n1 = 0; n4 = 0; first = -1;
    for (int k = 1; k <= 32; k++) begin
      lvl = ((k - 1) % 4) < 2;
      step(lvl, 1'b0, 1'b0);
      if (tk1 && first < 0) first = k;
      if (k == 20) begin
        check("t1_sec_div1", {24'h0, sc1}, 32'h05);
        check("t1_ticks_div1", n1, 5);
      end
    end
    check("t1_first_tick_edge", first, 3);
    check("t2_sec_div4", {24'h0, sc4}, 32'h02);
    check("t2_ticks_div4", n4, 2);
    check("t2_sec_div1", {24'h0, sc1}, 32'h08);

    // Day wrap from 23:59:00
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat (23) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (59) step(1'b0, 1'b0, 1'b1);
    check("t3_set_hm", {16'h0, hr1, mn1}, 32'h2359);
    step(1'b0, 1'b1, 1'b0);
    check("t3_run_sec0", {22'h0, md1, sc1}, 32'h0);
    nw1 = 0; nwt1 = 0;
    rises(60);
    check("t3_wrap_count", nw1, 1);
    check("t3_wrap_with_tick", nwt1, 1);
    check("t3_midnight", {8'h0, hr1, mn1, sc1}, 32'h0);

    // Set-mode wraparound
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    check("t4_hour25", {8'h0, hr1, mn1, sc1}, 32'h010000);
    step(1'b0, 1'b1, 1'b0);
    repeat (61) step(1'b0, 1'b0, 1'b1);
    check("t4_min61", {8'h0, hr1, mn1, sc1}, 32'h010100);
    step(1'b0, 1'b1, 1'b0);

    // Key collisions (table) then sec_pulse with mode_key
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].lvl, tbl[i].mk, tbl[i].ik);
      check($sformatf("t5_vec%0d", i), {6'h0, hr1, mn1, sc1, md1},
            {6'h0, tbl[i].hour, tbl[i].min, tbl[i].sec, tbl[i].mode});
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("t5_pulse_and_mode", {21'h0, sc1, md1, tk1}, {21'h0, 8'h01, 2'd1, 1'b1});
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("t5_exit_clears_sec", {8'h0, hr1, mn1, sc1}, 32'h010100);

    // Asynchronous reset mid-count
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (34) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    rises(56);
    check("t6_at_123456", {8'h0, hr1, mn1, sc1}, 32'h123456);
    step(1'b1, 1'b0, 1'b0);
    #2;
    sys_rst_n  = 1'b0;
    clk_div_in = 1'b0;
    #1;
    check("t6_async_div1", {4'h0, hr1, mn1, sc1, md1, tk1, wr1}, 32'h0);
    check("t6_async_div4", {4'h0, hr4, mn4, sc4, md4, tk4, wr4}, 32'h0);
    do_reset();
    rises(3);
    check("t6_resume_div1", {8'h0, hr1, mn1, sc1}, 32'h000003);
    check("t6_resume_div4", {8'h0, hr4, mn4, sc4}, 32'h000000);

    // Randomized run against the model
    do_reset();
    lvl = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0) lvl = ~lvl;
      step(lvl, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
